// File: rtl/cve2_hpm_counter_bank.sv
// Machine counter bank (mcycle, minstret, mhpmcounterN, mhpmeventN, mcountinhibit) with wrap pulses.
// Reads are combinational, writes/increments land on the next clk_i edge; no backpressure, every access completes.
module cve2_hpm_counter_bank #(
    parameter int unsigned NumCounters  = 10,
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   instr_ret_i,
    input  logic [NumEvents-1:0]   event_i,
    input  logic                   stop_count_i,
    input  logic [11:0]            csr_addr_i,
    input  logic                   csr_we_i,
    input  logic [31:0]            csr_wdata_i,
    output logic [31:0]            csr_rdata_o,
    output logic                   csr_hit_o,
    output logic                   csr_illegal_o,
    output logic [NumCounters+1:0] ovf_o
);
    localparam int unsigned NumHpm     = (NumCounters > 0) ? NumCounters : 1;
    localparam logic [63:0] HpmInhBits = ((64'd1 << NumCounters) - 64'd1) << 3;
    localparam logic [31:0] InhMask    = HpmInhBits[31:0] | 32'h5;

    function automatic logic [63:0] merge_half(input logic [63:0] cur, input logic hi,
                                               input logic [31:0] wd);
        return hi ? {wd, cur[31:0]} : {cur[63:32], wd};
    endfunction

    logic [4:0] idx;
    logic       user_idx;
    logic       sel_lo, sel_hi, sel_evt, sel_inh, sel_ulo, sel_uhi;
    logic       we_cnt, we_evt;

    assign idx      = csr_addr_i[4:0];
    assign user_idx = (idx == 5'd0) || (idx == 5'd2);
    assign sel_lo   = (csr_addr_i[11:5] == 7'h58) && (idx != 5'd1);
    assign sel_hi   = (csr_addr_i[11:5] == 7'h5C) && (idx != 5'd1);
    assign sel_evt  = (csr_addr_i[11:5] == 7'h19) && (idx >= 5'd3);
    assign sel_inh  = (csr_addr_i == 12'h320);
    assign sel_ulo  = (csr_addr_i[11:5] == 7'h60) && user_idx;
    assign sel_uhi  = (csr_addr_i[11:5] == 7'h64) && user_idx;

    assign csr_hit_o     = sel_lo || sel_hi || sel_evt || sel_inh || sel_ulo || sel_uhi;
    assign csr_illegal_o = csr_we_i && (sel_ulo || sel_uhi);
    assign we_cnt        = csr_we_i && (sel_lo || sel_hi);
    assign we_evt        = csr_we_i && sel_evt;

    logic [63:0]             mcycle_q, minstret_q;
    logic [31:0]             inhibit_q;
    logic                    cyc_ovf_q, ret_ovf_q;
    logic                    cyc_inc, ret_inc, cyc_wr, ret_wr;
    logic [CounterWidth-1:0] hpm_cnt [NumHpm];
    logic [NumEvents-1:0]    hpm_evt [NumHpm];

    assign cyc_inc = !inhibit_q[0] && !stop_count_i;
    assign ret_inc = instr_ret_i && !inhibit_q[2] && !stop_count_i;
    assign cyc_wr  = we_cnt && (idx == 5'd0);
    assign ret_wr  = we_cnt && (idx == 5'd2);

    // A CSR write to a counter takes priority over its increment and suppresses the wrap pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            cyc_ovf_q  <= 1'b0;
            ret_ovf_q  <= 1'b0;
            inhibit_q  <= '0;
        end else begin
            cyc_ovf_q <= 1'b0;
            ret_ovf_q <= 1'b0;
            if (cyc_wr) begin
                mcycle_q <= merge_half(mcycle_q, sel_hi, csr_wdata_i);
            end else if (cyc_inc) begin
                mcycle_q  <= mcycle_q + 64'd1;
                cyc_ovf_q <= &mcycle_q;
            end
            if (ret_wr) begin
                minstret_q <= merge_half(minstret_q, sel_hi, csr_wdata_i);
            end else if (ret_inc) begin
                minstret_q <= minstret_q + 64'd1;
                ret_ovf_q  <= &minstret_q;
            end
            if (csr_we_i && sel_inh) begin
                inhibit_q <= csr_wdata_i & InhMask;
            end
        end
    end

    assign ovf_o[0] = cyc_ovf_q;
    assign ovf_o[1] = ret_ovf_q;

    for (genvar k = 0; k < NumCounters; k++) begin : g_hpm
        logic [CounterWidth-1:0] cnt_q;
        logic [NumEvents-1:0]    evt_q;
        logic                    ovf_q, cnt_wr, cnt_inc;

        assign cnt_wr  = we_cnt && (idx == 5'(k + 3));
        assign cnt_inc = (|(evt_q & event_i)) && !inhibit_q[k+3] && !stop_count_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                evt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= 1'b0;
                if (cnt_wr) begin
                    cnt_q <= CounterWidth'(merge_half(64'(cnt_q), sel_hi, csr_wdata_i));
                end else if (cnt_inc) begin
                    cnt_q <= cnt_q + CounterWidth'(1);
                    ovf_q <= &cnt_q;
                end
                if (we_evt && (idx == 5'(k + 3))) begin
                    evt_q <= csr_wdata_i[NumEvents-1:0];
                end
            end
        end

        assign hpm_cnt[k]  = cnt_q;
        assign hpm_evt[k]  = evt_q;
        assign ovf_o[k+2]  = ovf_q;
    end

    if (NumCounters == 0) begin : g_no_hpm
        assign hpm_cnt[0] = '0;
        assign hpm_evt[0] = '0;
    end

    logic [63:0] cnt_rd;
    logic [31:0] evt_rd;

    // Unimplemented indices fall through to zero.
    always_comb begin
        cnt_rd = '0;
        evt_rd = '0;
        if (idx == 5'd0) cnt_rd = mcycle_q;
        if (idx == 5'd2) cnt_rd = minstret_q;
        for (int k = 0; k < NumCounters; k++) begin
            if (idx == 5'(k + 3)) begin
                cnt_rd = 64'(hpm_cnt[k]);
                evt_rd = 32'(hpm_evt[k]);
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        if (sel_lo || sel_ulo) begin
            csr_rdata_o = cnt_rd[31:0];
        end else if (sel_hi || sel_uhi) begin
            csr_rdata_o = cnt_rd[63:32];
        end else if (sel_evt) begin
            csr_rdata_o = evt_rd;
        end else if (sel_inh) begin
            csr_rdata_o = inhibit_q;
        end
    end
endmodule

// File: tb/tb_cve2_hpm_counter_bank.sv
// Directed bench: default bank (10 x 40 bit) and a small bank (2 x 16 bit) share all inputs.
module tb_cve2_hpm_counter_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_ret;
    logic [15:0] event_v;
    logic        stop_count;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;

    logic [31:0] rdata_a, rdata_b;
    logic        hit_a, hit_b, ill_a, ill_b;
    logic [11:0] ovf_a;
    logic [3:0]  ovf_b;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_edge = 0;
    logic [63:0] exp_cyc;

    always #5 clk = ~clk;

    cve2_hpm_counter_bank u_dut_a (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_ret_i   (instr_ret),
        .event_i       (event_v),
        .stop_count_i  (stop_count),
        .csr_addr_i    (csr_addr),
        .csr_we_i      (csr_we),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (rdata_a),
        .csr_hit_o     (hit_a),
        .csr_illegal_o (ill_a),
        .ovf_o         (ovf_a)
    );

    cve2_hpm_counter_bank #(
        .NumCounters  (2),
        .CounterWidth (16),
        .NumEvents    (16)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_ret_i   (instr_ret),
        .event_i       (event_v),
        .stop_count_i  (stop_count),
        .csr_addr_i    (csr_addr),
        .csr_we_i      (csr_we),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (rdata_b),
        .csr_hit_o     (hit_b),
        .csr_illegal_o (ill_b),
        .ovf_o         (ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            n_edge++;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_we    = 1'b1;
        csr_wdata = d;
        tick(1);
        csr_we    = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        instr_ret  = 1'b0;
        event_v    = '0;
        stop_count = 1'b0;
        csr_addr   = '0;
        csr_we     = 1'b0;
        csr_wdata  = '0;

        // Reset state
        rd(12'hB00);
        check("rst_mcycle", 64'(rdata_a), 64'h0);
        check("rst_ovf_a", 64'(ovf_a), 64'h0);
        check("rst_ovf_b", 64'(ovf_b), 64'h0);
        #10;
        rst_n = 1'b1;

        // 100 idle cycles
        tick(100);
        rd(12'hB00); check("mcycle_100", 64'(rdata_a), 64'd100);
        check("mcycle_100_b", 64'(rdata_b), 64'd100);
        rd(12'hB80); check("mcycleh_0", 64'(rdata_a), 64'h0);
        rd(12'hC00); check("cycle_alias", 64'(rdata_a), 64'd100);
        rd(12'hB03); check("hpm3_idle", 64'(rdata_a), 64'h0);
        rd(12'hB0C); check("hpm12_idle", 64'(rdata_a), 64'h0);

        // Event mask selects bit 2 only
        wr(12'h323, 32'h5);
        event_v = 16'h4; tick(7);
        event_v = 16'h2; tick(3);
        event_v = 16'h0;
        rd(12'hB03); check("hpm3_cnt7", 64'(rdata_a), 64'd7);
        check("hpm3_cnt7_b", 64'(rdata_b), 64'd7);
        rd(12'h323); check("evt3_rd", 64'(rdata_a), 64'h5);
        wr(12'h324, 32'hFFFF_FFFF);
        rd(12'h324); check("evt4_trunc", 64'(rdata_a), 64'h0000_FFFF);

        // 40-bit wrap and overflow pulse
        wr(12'hB83, 32'hFF);
        rd(12'hB83); check("hpm3h_wr", 64'(rdata_a), 64'hFF);
        check("hpm3h_b_ign", 64'(rdata_b), 64'h0);
        wr(12'hB03, 32'hFFFF_FFFE);
        event_v = 16'h1;
        tick(1);
        check("ovf_pre_wrap", 64'(ovf_a), 64'h0);
        tick(1);
        event_v = 16'h0;
        rd(12'hB03); check("hpm3_wrapped", 64'(rdata_a), 64'h0);
        rd(12'hB83); check("hpm3h_wrapped", 64'(rdata_a), 64'h0);
        check("ovf_a_pulse", 64'(ovf_a), 64'h004);
        check("ovf_b_pulse", 64'(ovf_b), 64'h4);
        tick(1);
        check("ovf_a_single", 64'(ovf_a), 64'h0);

        // Write beats same-cycle increment; read-only alias write
        instr_ret = 1'b1;
        wr(12'hB02, 32'h10);
        rd(12'hB02); check("minstret_wr_wins", 64'(rdata_a), 64'h10);
        tick(1);
        instr_ret = 1'b0;
        rd(12'hB02); check("minstret_inc", 64'(rdata_a), 64'h11);
        csr_addr = 12'hC02; csr_we = 1'b1; csr_wdata = 32'hDEAD;
        #1;
        check("illegal_c02", 64'(ill_a), 64'h1);
        check("hit_c02", 64'(hit_a), 64'h1);
        check("instret_alias", 64'(rdata_a), 64'h11);
        tick(1);
        csr_we = 1'b0;
        rd(12'hB02); check("minstret_ro_kept", 64'(rdata_a), 64'h11);
        check("illegal_idle", 64'(ill_a), 64'h0);

        // mcountinhibit masking and freezing
        wr(12'h320, 32'hFFFF_FFFF);
        exp_cyc = 64'(n_edge);
        rd(12'h320);
        check("inhibit_a", 64'(rdata_a), 64'h1FFD);
        check("inhibit_b", 64'(rdata_b), 64'h1D);
        tick(50);
        rd(12'hB00); check("mcycle_inhibited", 64'(rdata_a), exp_cyc);
        wr(12'h320, 32'h0);
        stop_count = 1'b1;
        event_v    = 16'h1;
        tick(20);
        rd(12'hB00); check("mcycle_stopped", 64'(rdata_a), exp_cyc);
        rd(12'hB03); check("hpm3_stopped", 64'(rdata_a), 64'h0);
        stop_count = 1'b0;
        event_v    = 16'h0;
        tick(1);
        rd(12'hB00); check("mcycle_resumed", 64'(rdata_a), exp_cyc + 64'd1);

        // Unimplemented indices and narrow counters
        rd(12'hB1F);
        check("hit_b1f", 64'(hit_a), 64'h1);
        check("rd_b1f", 64'(rdata_a), 64'h0);
        rd(12'hB01); check("hit_b01", 64'(hit_a), 64'h0);
        wr(12'hB05, 32'h77);
        rd(12'hB05); check("b_unimpl_rd", 64'(rdata_b), 64'h0);
        check("b_unimpl_hit", 64'(hit_b), 64'h1);
        wr(12'hB03, 32'h0001_2345);
        rd(12'hB03);
        check("a_lo_wr", 64'(rdata_a), 64'h0001_2345);
        check("b_lo_trunc", 64'(rdata_b), 64'h2345);
        wr(12'hB83, 32'hAB);
        rd(12'hB83);
        check("a_hi_wr", 64'(rdata_a), 64'hAB);
        check("b_hi_ign", 64'(rdata_b), 64'h0);

        // Asynchronous reset while an overflow pulse is live
        wr(12'hB03, 32'h0000_FFFF);
        event_v = 16'h1;
        tick(1);
        event_v = 16'h0;
        check("b_ovf_16", 64'(ovf_b), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ovf_b", 64'(ovf_b), 64'h0);
        rd(12'hB00); check("arst_mcycle", 64'(rdata_a), 64'h0);
        rd(12'hB03); check("arst_hpm3_b", 64'(rdata_b), 64'h0);
        tick(1);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
